i2s_dac_rx: RTL

- I2S clock master and serial receiver for the audio DAC data stream.
- Generates BCLK and DACLRC from clk_50 and deserialises DACDAT into 16-bit left/right sample pairs.
- Presents each pair on a valid/ready handshake.
- Used as a loopback and monitor endpoint facing the SOPC audio conduit (BCLK/DACLRC inputs, DACDAT output) in place of the WM8731 codec.

---
 rtl/i2s_dac_rx_pkg.sv | 19 +
 rtl/i2s_dac_rx_if.sv | 30 +++
 rtl/i2s_dac_rx_bclk_gen.sv | 58 +++++
 rtl/i2s_dac_rx.sv | 106 ++++++++++
 4 files changed

// File: rtl/i2s_dac_rx_pkg.sv
// Shared constants and types for the I2S DAC-side receiver.
// Holds default timing parameters, the channel encoding and a frame-length helper.
package i2s_rx_pkg;

  localparam int BCLK_DIV_DEF    = 16;
  localparam int SAMPLE_BITS_DEF = 16;
  localparam int SLOT_BITS_DEF   = 32;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } channel_t;

  // One frame is two slots of SLOT_BITS BCLK periods, each 2*BCLK_DIV clk cycles.
  function automatic int frame_cycles(input int bclk_div, input int slot_bits);
    return 4 * slot_bits * bclk_div;
  endfunction

endpackage

// File: rtl/i2s_dac_rx_if.sv
// Sample-pair handshake bundle between the I2S receiver and its consumer.
// master = receiver side, slave = consumer side.
interface i2s_dac_rx_if #(
  parameter int SAMPLE_BITS = 16
);
  logic [SAMPLE_BITS-1:0] left_sample;
  logic [SAMPLE_BITS-1:0] right_sample;
  logic                   sample_valid;
  logic                   sample_ready;
  logic                   overrun;
  logic                   overrun_clr;

  modport master (
    output left_sample,
    output right_sample,
    output sample_valid,
    output overrun,
    input  sample_ready,
    input  overrun_clr
  );

  modport slave (
    input  left_sample,
    input  right_sample,
    input  sample_valid,
    input  overrun,
    output sample_ready,
    output overrun_clr
  );
endinterface

// File: rtl/i2s_dac_rx_bclk_gen.sv
// BCLK/DACLRC generator: divides clk into BCLK, counts bits per frame and
// flags BCLK rise events for the capture logic.
module i2s_bclk_gen
  import i2s_rx_pkg::*;
#(
  parameter  int BCLK_DIV  = BCLK_DIV_DEF,
  parameter  int SLOT_BITS = SLOT_BITS_DEF,
  localparam int BC_W      = $clog2(2 * SLOT_BITS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  output logic            bclk,
  output logic            lrc,
  output logic            rise,
  output logic [BC_W-1:0] bit_cnt
);

  localparam int DIV_W = $clog2(BCLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [BC_W-1:0]  BIT_LAST = BC_W'(2 * SLOT_BITS - 1);
  localparam logic [BC_W-1:0]  SLOT_LEN = BC_W'(SLOT_BITS);

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic             fall;
  logic [BC_W-1:0]  bit_next;

  assign tick     = enable && (div_cnt == DIV_LAST);
  assign rise     = tick && !bclk;
  assign fall     = tick && bclk;
  assign bit_next = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;

  // lrc is updated together with bit_cnt so it switches on the BCLK falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
      bit_cnt <= '0;
      lrc     <= 1'b0;
    end else if (!enable) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
      bit_cnt <= '0;
      lrc     <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) begin
        bclk <= ~bclk;
      end
      if (fall) begin
        bit_cnt <= bit_next;
        lrc     <= (bit_next >= SLOT_LEN);
      end
    end
  end

endmodule

// File: rtl/i2s_dac_rx.sv
// I2S clock master and serial receiver: generates BCLK/DACLRC, deserialises
// DACDAT into left/right pairs and offers them on a valid/ready handshake.
module i2s_dac_rx
  import i2s_rx_pkg::*;
#(
  parameter int BCLK_DIV    = BCLK_DIV_DEF,
  parameter int SAMPLE_BITS = SAMPLE_BITS_DEF,
  parameter int SLOT_BITS   = SLOT_BITS_DEF
) (
  input  logic         clk_50,
  input  logic         reset_n,
  input  logic         enable,
  output logic         bclk_out,
  output logic         lrc_out,
  input  logic         dacdat_in,
  i2s_dac_rx_if.master bus
);

  localparam int BC_W = $clog2(2 * SLOT_BITS);
  localparam logic [BC_W-1:0] SLOT_LEN = BC_W'(SLOT_BITS);
  localparam logic [BC_W-1:0] LAST_POS = BC_W'(SAMPLE_BITS);

  logic                   rise;
  logic [BC_W-1:0]        bit_cnt;
  logic [BC_W-1:0]        slot_pos;
  channel_t               chan;
  logic                   dat_meta;
  logic                   dat_sync;
  logic [SAMPLE_BITS-1:0] shift_reg;
  logic [SAMPLE_BITS-1:0] shift_next;
  logic [SAMPLE_BITS-1:0] left_shadow;
  logic                   capture;
  logic                   last_bit;
  logic                   commit;

  i2s_bclk_gen #(
    .BCLK_DIV (BCLK_DIV),
    .SLOT_BITS(SLOT_BITS)
  ) u_bclk_gen (
    .clk    (clk_50),
    .rst_n  (reset_n),
    .enable (enable),
    .bclk   (bclk_out),
    .lrc    (lrc_out),
    .rise   (rise),
    .bit_cnt(bit_cnt)
  );

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      dat_meta <= 1'b0;
      dat_sync <= 1'b0;
    end else begin
      dat_meta <= dacdat_in;
      dat_sync <= dat_meta;
    end
  end

  // Position 0 of each slot is the I2S one-bit delay and carries no data.
  assign slot_pos   = (bit_cnt >= SLOT_LEN) ? bit_cnt - SLOT_LEN : bit_cnt;
  assign chan       = channel_t'(lrc_out);
  assign capture    = rise && (slot_pos != '0) && (slot_pos <= LAST_POS);
  assign last_bit   = rise && (slot_pos == LAST_POS);
  assign commit     = last_bit && (chan == CH_RIGHT);
  assign shift_next = {shift_reg[SAMPLE_BITS-2:0], dat_sync};

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg   <= '0;
      left_shadow <= '0;
    end else if (!enable) begin
      shift_reg <= '0;
    end else begin
      if (capture) begin
        shift_reg <= shift_next;
      end
      if (last_bit && (chan == CH_LEFT)) begin
        left_shadow <= shift_next;
      end
    end
  end

  // Handshake runs regardless of enable so a pending pair can still be drained.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      bus.left_sample  <= '0;
      bus.right_sample <= '0;
      bus.sample_valid <= 1'b0;
      bus.overrun      <= 1'b0;
    end else begin
      if (commit) begin
        bus.left_sample  <= left_shadow;
        bus.right_sample <= shift_next;
        bus.sample_valid <= 1'b1;
      end else if (bus.sample_valid && bus.sample_ready) begin
        bus.sample_valid <= 1'b0;
      end
      if (commit && bus.sample_valid && !bus.sample_ready) begin
        bus.overrun <= 1'b1;
      end else if (bus.overrun_clr) begin
        bus.overrun <= 1'b0;
      end
    end
  end

endmodule
